// File: rtl/fpu_divide_if.sv
// Handshake and result bundle between the stage-2 pipeline and the divide sequencer.
interface fpu_divide_if;
  logic        division_op;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        stall;
  logic        busy;
  logic        done;
  logic [25:0] quotient;
  logic [25:0] remainder;
  logic        sticky;

  modport master (
    output division_op, dividend, divisor,
    input  stall, busy, done, quotient, remainder, sticky
  );

  modport slave (
    input  division_op, dividend, divisor,
    output stall, busy, done, quotient, remainder, sticky
  );
endinterface

// File: rtl/fpu_divide_sequencer.sv
// Restoring fraction divider that stalls stage 2 for 26 quotient steps.
// Optional FPU_DIVIDE_EARLY_EXIT_EN: finish as soon as the partial remainder reaches zero.
module fpu_divide_sequencer (
  input  logic          clk,
  input  logic          reset,
  fpu_divide_if.slave   bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ITERATE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [25:0] q;
  logic [25:0] rem;
  logic [25:0] d;
  logic [25:0] quotient_r;
  logic [25:0] remainder_r;
  logic        sticky_r;

  logic        start;
  logic        rem_ge;
  logic        last_step;
  logic [25:0] q_step;
  logic [25:0] rem_step;
  logic [25:0] q_final;

  assign start         = (state == IDLE) && bus.division_op;
  // Reset must release the pipeline even while a division is being requested.
  assign bus.stall     = !reset && (start || (state == ITERATE));
  assign bus.busy      = (state == ITERATE);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.sticky    = sticky_r;

  always_comb begin
    rem_ge   = (rem >= d);
    rem_step = rem_ge ? ((rem - d) << 1) : (rem << 1);
    q_step   = (q << 1) | {25'b0, rem_ge};
`ifdef FPU_DIVIDE_EARLY_EXIT_EN
    // An early finish leaves fewer quotient bits; align them to the 26-bit result.
    last_step = (count == 5'd25) || (rem_step == '0);
    q_final   = q_step << (5'd25 - count);
`else
    last_step = (count == 5'd25);
    q_final   = q_step;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      q           <= '0;
      rem         <= '0;
      d           <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      sticky_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= {2'b00, bus.dividend};
            d     <= {2'b00, bus.divisor};
            q     <= '0;
            count <= '0;
            state <= ITERATE;
          end
        end
        ITERATE: begin
          rem <= rem_step;
          if (last_step) begin
            q           <= q_final;
            quotient_r  <= q_final;
            remainder_r <= rem_step;
            sticky_r    <= |rem_step;
            state       <= DONE;
          end else begin
            q     <= q_step;
            count <= count + 5'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
